keypad_matrix_scan: RTL
=======================

Name: keypad_matrix_scan

Overview:
4x4 matrix keypad scanner. It is the input-side counterpart of the multiplexed 7-segment display driver. It drives one active-low column at a time and samples the four active-low rows. Each press is debounced into a single-cycle key event with a 4-bit key code, and the code is shifted into a 32-bit value register that can feed the display's 32-bit data input directly.

Parameters:
SCAN_DIV, 16, width of the free-running scan counter; one scan tick every 2^SCAN_DIV sys_clk cycles (min 2).
DEBOUNCE, 4, consecutive matching scan ticks needed to accept a press or a release (min 2, max 15).

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous reset, active-low
key_row  input  4  row sense lines, active-low, externally pulled up, asynchronous to sys_clk
clear  input  1  synchronous clear of key_value, active-high
key_col  output  4  column drive, active-low, exactly one bit low at all times
key_valid  output  1  one-cycle pulse per accepted press
key_code  output  4  code of the last accepted press, held until the next press
key_value  output  32  shift register of accepted codes; newest code in bits [3:0]

Behaviour:
- Reset is asynchronous, active-low. Reset values: key_col=4'b1110, key_valid=0, key_code=0, key_value=0, state=SCAN, column index=0, all counters=0.
- key_row passes through a 2-flop synchronizer; all decisions use the synchronized value (rs).
- scan_cnt (SCAN_DIV bits) free-runs and wraps. tick=1 when scan_cnt is all ones. State transitions happen only on tick, except key_valid deassert and clear.
- key_col = ~(4'b0001 << col). col changes only on the tick edge, so rows get a full scan period to settle before they are sampled.
- Code mapping: code = {row_idx[1:0], col[1:0]}, where row_idx is the index of the single low bit of rs.
- "Single" means exactly one bit of rs is low. Zero low bits or two or more low bits count as no press (ghosting rejected).
- SCAN state, on tick:
  - rs single: latch row_idx and col, set deb_cnt=1, go to DEBOUNCE.
  - Otherwise: col <= col+1 (3 wraps to 0).
- DEBOUNCE state, on tick (col held):
  - rs equals the latched single row and deb_cnt==DEBOUNCE-1: register key_valid=1, key_code=code, key_value={key_value[27:0],code}; go to HOLD with deb_cnt=0.
  - rs equals the latched row, otherwise: deb_cnt++.
  - Any other rs: go to SCAN with col unchanged and no event.
  - Net effect: key_valid rises on the edge of the DEBOUNCE-th consecutive matching tick.
- HOLD state, on tick (col held):
  - rs==4'b1111: deb_cnt++. When deb_cnt reaches DEBOUNCE, go to SCAN with col+1 and deb_cnt=0.
  - Any low bit in rs: deb_cnt=0.
  - Auto-repeat is not supported; at most one key_valid per press.
- key_valid is high for exactly one sys_clk cycle.
- key_value shifts left 4 bits per press; the oldest digit is lost after 8 presses. It never shifts without a key_valid.
- clear: key_value <= 0 on the next edge. If clear coincides with an accepted press, clear wins: key_value=0, while key_valid still pulses and key_code still updates. State and scan are unaffected by clear.
- A reset asserted mid-DEBOUNCE or mid-HOLD returns everything to the reset values immediately; no key_valid is emitted.

Test Plan:
- Reset: assert sys_rst_n=0 with rows idle -> key_col=1110, key_valid=0, key_code=0, key_value=0. Release reset, rows idle, SCAN_DIV=4 -> key_col cycles 1110,1101,1011,0111,1110, stepping every 16 cycles.
- Clean press: SCAN_DIV=4, DEBOUNCE=4; hold row2 low only while col1 is driven, for 10 ticks, then release -> exactly one key_valid, key_code=9, key_value=0x00000009. Then press row0/col3 -> key_code=3, key_value=0x00000093.
- Bounce: row1/col0 low for 2 ticks, high for 1, low for 2, then released -> no key_valid; key_value unchanged; scan resumes.
- Ghost: rows 0 and 3 low together on col2 for 10 ticks -> no key_valid; col keeps advancing.
- Wrap and clear: nine presses with codes 1..9 -> key_value=0x23456789. Then assert clear on the same cycle as a press of code 0xA -> key_valid=1, key_code=A, key_value=0.
- Reset mid-hold: hold a key into HOLD, pulse sys_rst_n low -> outputs return to reset values. With the key still held after release of reset, exactly one new key_valid occurs after DEBOUNCE matching ticks.

Source files
------------

// File: rtl/keypad_if.sv
// Keypad scanner bus: row sense in, column drive out, and the debounced key event outputs.
interface keypad_if;
  logic [3:0]  key_row;
  logic        clear;
  logic [3:0]  key_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] key_value;

  modport master (
    output key_row, clear,
    input  key_col, key_valid, key_code, key_value
  );

  modport slave (
    input  key_row, clear,
    output key_col, key_valid, key_code, key_value
  );
endinterface

// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad scanner with per-press debounce; accepted codes shift into a 32-bit value.
//   state       | meaning
//   ST_SCAN     | stepping columns once per scan tick, looking for a single low row
//   ST_DEBOUNCE | column held, counting consecutive ticks that match the latched row
//   ST_HOLD     | press accepted, column held until DEBOUNCE consecutive idle ticks
module keypad_matrix_scan #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input logic     sys_clk,
  input logic     sys_rst_n,
  keypad_if.slave bus
);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HOLD} state_t;

  localparam logic [3:0]          DEB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [3:0]          DEB_MAX  = 4'(DEBOUNCE);
  localparam logic [SCAN_DIV-1:0] CNT_ONE  = SCAN_DIV'(1);

  state_t               state;
  logic [3:0]           row_meta;
  logic [3:0]           rs;
  logic [SCAN_DIV-1:0]  scan_cnt;
  logic [1:0]           col;
  logic [1:0]           row_lat;
  logic [3:0]           deb_cnt;
  logic [3:0]           col_q;
  logic                 valid_q;
  logic [3:0]           code_q;
  logic [31:0]          value_q;

  logic                 tick;
  logic                 row_single;
  logic [1:0]           row_idx;
  logic                 row_match;
  logic                 accept;
  logic [3:0]           acc_code;

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  assign tick      = &scan_cnt;
  assign row_match = (rs == ~(4'b0001 << row_lat));
  assign accept    = tick && (state == ST_DEBOUNCE) && row_match && (deb_cnt == DEB_LAST);
  assign acc_code  = {row_lat, col};

  // Zero or multiple low rows are both treated as "no press" so ghosted combinations never register.
  always_comb begin
    row_single = 1'b0;
    row_idx    = 2'd0;
    case (rs)
      4'b1110: begin row_single = 1'b1; row_idx = 2'd0; end
      4'b1101: begin row_single = 1'b1; row_idx = 2'd1; end
      4'b1011: begin row_single = 1'b1; row_idx = 2'd2; end
      4'b0111: begin row_single = 1'b1; row_idx = 2'd3; end
      default: begin row_single = 1'b0; row_idx = 2'd0; end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_SCAN;
      row_meta <= 4'hF;
      rs       <= 4'hF;
      scan_cnt <= '0;
      col      <= 2'd0;
      row_lat  <= 2'd0;
      deb_cnt  <= 4'd0;
      col_q    <= 4'b1110;
      valid_q  <= 1'b0;
      code_q   <= 4'd0;
      value_q  <= 32'd0;
    end else begin
      row_meta <= bus.key_row;
      rs       <= row_meta;
      scan_cnt <= scan_cnt + CNT_ONE;
      valid_q  <= 1'b0;

      // Clear takes priority over a coincident press; the event itself still goes out.
      if (bus.clear)
        value_q <= 32'd0;
      else if (accept)
        value_q <= {value_q[27:0], acc_code};

      if (accept) begin
        valid_q <= 1'b1;
        code_q  <= acc_code;
      end

      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (row_single) begin
              row_lat <= row_idx;
              deb_cnt <= 4'd1;
              state   <= ST_DEBOUNCE;
            end else begin
              col   <= col + 2'd1;
              col_q <= col_drive(col + 2'd1);
            end
          end
          ST_DEBOUNCE: begin
            if (row_match) begin
              if (deb_cnt == DEB_LAST) begin
                deb_cnt <= 4'd0;
                state   <= ST_HOLD;
              end else begin
                deb_cnt <= deb_cnt + 4'd1;
              end
            end else begin
              deb_cnt <= 4'd0;
              state   <= ST_SCAN;
            end
          end
          ST_HOLD: begin
            if (rs == 4'hF) begin
              if (deb_cnt + 4'd1 == DEB_MAX) begin
                deb_cnt <= 4'd0;
                col     <= col + 2'd1;
                col_q   <= col_drive(col + 2'd1);
                state   <= ST_SCAN;
              end else begin
                deb_cnt <= deb_cnt + 4'd1;
              end
            end else begin
              deb_cnt <= 4'd0;
            end
          end
          default: begin
            deb_cnt <= 4'd0;
            state   <= ST_SCAN;
          end
        endcase
      end
    end
  end

  assign bus.key_col   = col_q;
  assign bus.key_valid = valid_q;
  assign bus.key_code  = code_q;
  assign bus.key_value = value_q;

endmodule
